// File: rtl/timer_sched_pkg.sv
// Shared FSM states, timer register map and bus-write helper for timer_request_scheduler.
// Also used by the arbiter; no logic of its own.
package timer_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_STAT,
        ST_WR_CTRL,
        ST_WAIT_IRQ,
        ST_CLR_STAT,
        ST_CTRL_OFF,
        ST_DONE
    } sched_state_t;

    localparam logic [2:0] TMR_ADDR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_ADDR_PERIOD_H = 3'd3;

    localparam logic [15:0] CTRL_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_CONT  = 16'h0002;
    localparam logic [15:0] CTRL_START = 16'h0004;
    localparam logic [15:0] CTRL_STOP  = 16'h0008;

    typedef struct packed {
        logic        cs;
        logic        wr_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } tmr_bus_t;

    localparam tmr_bus_t TMR_BUS_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: 3'd0, data: 16'h0000};

    function automatic tmr_bus_t tmr_wr(input logic [2:0] a, input logic [15:0] d);
        tmr_wr = '{cs: 1'b1, wr_n: 1'b0, addr: a, data: d};
    endfunction

endpackage

// File: rtl/timer_sched_arb.sv
// Combinational one-hot arbiter; fixed priority (index 0 highest) by default,
// round-robin when TIMER_SCHED_RR_EN is defined (pointer advances on adv_i).
module timer_sched_arb
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
`ifdef TIMER_SCHED_RR_EN
    input  logic             clk,
    input  logic             reset_n,
    input  logic             adv_i,
`endif
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

    logic [IDX_W-1:0] base;

`ifdef TIMER_SCHED_RR_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    assign ptr_d = (idx_o == IDX_W'(N_REQ - 1)) ? '0 : idx_o + 1'b1;
    assign base  = ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign base = '0;
`endif

    // Scan candidates starting at base, wrapping modulo N_REQ.
    logic [IDX_W:0] cand;
    logic           found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, base} + (IDX_W+1)'(k);
            if (cand >= N_W) cand = cand - N_W;
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                idx_o                   = cand[IDX_W-1:0];
                gnt_o[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_request_scheduler.sv
// Shares one interval-timer slave among N_REQ one-shot delay requesters; START lands 4 cycles after grant, done 3 cycles after irq.
// Optional round-robin arbitration via TIMER_SCHED_RR_EN; losers simply wait in IDLE while req stays high.
module timer_request_scheduler
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_period,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic [2:0]           tmr_address,
    output logic                 tmr_chipselect,
    output logic                 tmr_write_n,
    output logic [15:0]          tmr_writedata,
    input  logic                 tmr_irq
);

    sched_state_t     state_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] done_q;
    logic             busy_q;
    logic [15:0]      period_hi_q;
    tmr_bus_t         bus_q;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic [31:0]      periods [N_REQ];
    logic [31:0]      win_period;

    timer_sched_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
`ifdef TIMER_SCHED_RR_EN
        .clk     (clk),
        .reset_n (reset_n),
        .adv_i   ((state_q == ST_IDLE) && (|req)),
`endif
        .req_i   (req),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) periods[i] = req_period[32*i +: 32];
    end
    assign win_period = periods[arb_idx];

    // The low half goes straight onto the bus at grant; only the high half is needed later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            period_hi_q <= '0;
            bus_q       <= TMR_BUS_IDLE;
        end else begin
            done_q <= '0;
            bus_q  <= TMR_BUS_IDLE;
            unique case (state_q)
                ST_IDLE: if (|req) begin
                    grant_q     <= arb_gnt;
                    period_hi_q <= win_period[31:16];
                    busy_q      <= 1'b1;
                    bus_q       <= tmr_wr(TMR_ADDR_PERIOD_L, win_period[15:0]);
                    state_q     <= ST_WR_PL;
                end
                ST_WR_PL: begin
                    bus_q   <= tmr_wr(TMR_ADDR_PERIOD_H, period_hi_q);
                    state_q <= ST_WR_PH;
                end
                // Status clear separates the period writes from START so START never
                // coincides with the timer's post-period-write reload cycle.
                ST_WR_PH: begin
                    bus_q   <= tmr_wr(TMR_ADDR_STATUS, 16'h0000);
                    state_q <= ST_WR_STAT;
                end
                ST_WR_STAT: begin
                    bus_q   <= tmr_wr(TMR_ADDR_CONTROL, CTRL_START | CTRL_ITO);
                    state_q <= ST_WR_CTRL;
                end
                ST_WR_CTRL: state_q <= ST_WAIT_IRQ;
                ST_WAIT_IRQ: if (tmr_irq) begin
                    bus_q   <= tmr_wr(TMR_ADDR_STATUS, 16'h0000);
                    state_q <= ST_CLR_STAT;
                end
                ST_CLR_STAT: begin
                    bus_q   <= tmr_wr(TMR_ADDR_CONTROL, CTRL_STOP);
                    state_q <= ST_CTRL_OFF;
                end
                ST_CTRL_OFF: begin
                    done_q  <= grant_q;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign done           = done_q;
    assign grant          = grant_q;
    assign busy           = busy_q;
    assign tmr_address    = bus_q.addr;
    assign tmr_chipselect = bus_q.cs;
    assign tmr_write_n    = bus_q.wr_n;
    assign tmr_writedata  = bus_q.data;

endmodule
